button_debouncer: RTL

Debounces and conditions up to N_BTN raw push-button inputs, using the slow square wave from the clock divider as its sampling tick. It sits directly downstream of the clock divider, consuming `clk_dv`, and directly upstream of the lab control logic. All logic runs on the fast `clk`; `clk_dv` is treated as data and edge-detected, never used as a clock. Outputs are a clean level per button plus one-cycle press, release and auto-repeat pulses.

---
 rtl/button_debouncer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/button_debouncer.sv
// button_debouncer: synchronises raw push-button inputs and debounces them,
// using the slow clk_dv square wave as a sampling tick. Produces a clean level
// per button plus one-cycle press, release and auto-repeat pulses.
module button_debouncer #(
  parameter int unsigned N_BTN        = 4,
  parameter int unsigned STABLE_TICKS = 4,
  parameter int unsigned REPEAT_DELAY = 50,
  parameter int unsigned REPEAT_RATE  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_dv,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat
);

  localparam int unsigned SW   = $clog2(STABLE_TICKS + 1);
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RW   = $clog2(RMAX + 1);

  localparam logic [SW-1:0] S_LIM = SW'(STABLE_TICKS);
  localparam logic [RW-1:0] D_LIM = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] R_LIM = RW'(REPEAT_RATE);

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DELAY,
    RPT_REPEAT
  } rpt_state_e;

  // Synchroniser and edge-detector flops
  logic [N_BTN-1:0] btn_s1_q, btn_s2_q;
  logic             dv_s1_q, dv_s2_q, dv_s3_q;
  logic             tick;

  // Debounce and repeat state
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] press_q, press_d;
  logic [N_BTN-1:0] release_q, release_d;
  logic [N_BTN-1:0] repeat_q, repeat_d;
  logic [SW-1:0]    scnt_q [N_BTN];
  logic [SW-1:0]    scnt_d [N_BTN];
  logic [RW-1:0]    rcnt_q [N_BTN];
  logic [RW-1:0]    rcnt_d [N_BTN];
  rpt_state_e       state_q [N_BTN];
  rpt_state_e       state_d [N_BTN];

  // Level-change events of the current tick, consumed by the repeat FSM
  logic [N_BTN-1:0] rise, fall;
  logic [SW-1:0]    s_inc;
  logic [RW-1:0]    r_inc;

  // Two-flop synchronisers for buttons and clk_dv, plus clk_dv delay flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      dv_s1_q  <= 1'b0;
      dv_s2_q  <= 1'b0;
      dv_s3_q  <= 1'b0;
    end else begin
      btn_s1_q <= btn_raw;
      btn_s2_q <= btn_s1_q;
      dv_s1_q  <= clk_dv;
      dv_s2_q  <= dv_s1_q;
      dv_s3_q  <= dv_s2_q;
    end
  end

  assign tick = dv_s2_q & ~dv_s3_q;

  // Per-button debounce counter, edge events and repeat FSM next state
  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    repeat_d  = '0;
    rise      = '0;
    fall      = '0;
    s_inc     = '0;
    r_inc     = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      scnt_d[i]  = scnt_q[i];
      rcnt_d[i]  = rcnt_q[i];
      state_d[i] = state_q[i];

      s_inc = scnt_q[i] + SW'(1);
      if (tick) begin
        if (btn_s2_q[i] != level_q[i]) begin
          if (s_inc == S_LIM) begin
            level_d[i] = ~level_q[i];
            scnt_d[i]  = '0;
            rise[i]    = ~level_q[i];
            fall[i]    = level_q[i];
          end else begin
            scnt_d[i] = s_inc;
          end
        end else begin
          scnt_d[i] = '0;
        end
      end
      press_d[i]   = rise[i];
      release_d[i] = fall[i];

      // Release is checked first so it overrides a repeat due on the same tick
      r_inc = rcnt_q[i] + RW'(1);
      if (fall[i]) begin
        state_d[i] = RPT_IDLE;
        rcnt_d[i]  = '0;
      end else begin
        case (state_q[i])
          RPT_IDLE: begin
            if (rise[i]) begin
              state_d[i] = RPT_DELAY;
              rcnt_d[i]  = '0;
            end
          end
          RPT_DELAY: begin
            if (tick) begin
              if (r_inc == D_LIM) begin
                repeat_d[i] = 1'b1;
                state_d[i]  = RPT_REPEAT;
                rcnt_d[i]   = '0;
              end else begin
                rcnt_d[i] = r_inc;
              end
            end
          end
          RPT_REPEAT: begin
            if (tick) begin
              if (r_inc == R_LIM) begin
                repeat_d[i] = 1'b1;
                rcnt_d[i]   = '0;
              end else begin
                rcnt_d[i] = r_inc;
              end
            end
          end
          default: begin
            state_d[i] = RPT_IDLE;
            rcnt_d[i]  = '0;
          end
        endcase
      end
    end
  end

  // Debounce/repeat state registers and registered output pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      repeat_q  <= '0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        scnt_q[i]  <= '0;
        rcnt_q[i]  <= '0;
        state_q[i] <= RPT_IDLE;
      end
    end else begin
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        scnt_q[i]  <= scnt_d[i];
        rcnt_q[i]  <= rcnt_d[i];
        state_q[i] <= state_d[i];
      end
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_repeat  = repeat_q;

endmodule
